// File: rtl/uart_pkg.sv
// uart_pkg
//   Definitions shared by the UART receiver and transmitter.
//   - uart_state_e : frame-level FSM states.
//   - DEF_*        : default frame geometry, in s_ticks oversampling strobes.
//   - max3 / cnt_width : helpers for sizing counters from the tick parameters.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Serial bits per frame between start and stop: 8 data bits + 1 even-parity bit.
  localparam int DEF_DATA_BITS = 9;
  // Stop-bit length in s_ticks.
  localparam int DEF_SP_TICKS  = 16;
  // Start-bit mid-point in s_ticks.
  localparam int DEF_ST_TICKS  = 8;
  // Data and parity bit length in s_ticks.
  localparam int DEF_DT_TICKS  = 16;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Counter width that can hold values 0..n-1. It never drops below one
  // bit, so degenerate parameter choices still elaborate.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if
//   Serial-side and result-side signals of the UART receiver.
//   rx           : serial line, idle high (asynchronous to clk)
//   s_ticks      : one-clk-wide oversampling strobe
//   data_out     : last received data word (Data_bits-1 bits)
//   rx_done_tick : one-clk pulse when a frame completes
//   parity_err   : even-parity mismatch on the last frame
//   frame_err    : stop bit sampled low on the last frame
//   Modports: master = line/strobe driver that consumes the results;
//             slave  = the receiver.
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int Data_bits = DEF_DATA_BITS
);

  logic                 rx;
  logic                 s_ticks;
  logic [Data_bits-2:0] data_out;
  logic                 rx_done_tick;
  logic                 parity_err;
  logic                 frame_err;

  modport master (
    output rx,
    output s_ticks,
    input  data_out,
    input  rx_done_tick,
    input  parity_err,
    input  frame_err
  );

  modport slave (
    input  rx,
    input  s_ticks,
    output data_out,
    output rx_done_tick,
    output parity_err,
    output frame_err
  );

endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync
//   Two-flop synchronizer that brings the asynchronous serial line into the
//   clk domain. Both flops reset to 1, the idle level of the line, so leaving
//   reset never looks like a start bit.
//   clk      : clock, rising edge
//   Reset    : synchronous, active-high
//   async_in : asynchronous input
//   sync_out : synchronized output, two clk behind async_in
module uart_rx_sync (
  input  logic clk,
  input  logic Reset,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q;

  // The first flop may go metastable; only the second flop is used downstream.
  always_ff @(posedge clk) begin
    if (Reset) begin
      meta_q   <= 1'b1;
      sync_out <= 1'b1;
    end else begin
      meta_q   <= async_in;
      sync_out <= meta_q;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx
//   Oversampling UART receiver. It finds the start bit on the synchronized
//   line, re-checks it at its mid-point, then samples each data/parity bit and
//   the stop bit one full bit time apart, i.e. near the middle of each bit.
//   Bits arrive LSB first; the last serial bit before stop is even parity.
//   Parameters (all lengths in s_ticks):
//     Data_bits : serial bits per frame between start and stop (data + parity)
//     Sp_ticks  : stop-bit sample point after the last data/parity sample
//     St_ticks  : start-bit mid-point after the falling edge
//     Dt_ticks  : data/parity bit length
//   Ports:
//     clk   : clock, rising edge
//     Reset : synchronous, active-high
//     bus   : uart_rx_if slave (rx, s_ticks in; data_out, rx_done_tick,
//             parity_err, frame_err out)
module uart_rx
  import uart_pkg::*;
#(
  parameter int Data_bits = DEF_DATA_BITS,
  parameter int Sp_ticks  = DEF_SP_TICKS,
  parameter int St_ticks  = DEF_ST_TICKS,
  parameter int Dt_ticks  = DEF_DT_TICKS
) (
  input  logic     clk,
  input  logic     Reset,
  uart_rx_if.slave bus
);

  localparam int TickW = cnt_width(max3(Sp_ticks, St_ticks, Dt_ticks));
  localparam int BitW  = cnt_width(Data_bits);

  localparam logic [TickW-1:0] St_last  = TickW'(St_ticks - 1);
  localparam logic [TickW-1:0] Dt_last  = TickW'(Dt_ticks - 1);
  localparam logic [TickW-1:0] Sp_last  = TickW'(Sp_ticks - 1);
  localparam logic [BitW-1:0]  Bit_last = BitW'(Data_bits - 1);

  logic rx_s;

  uart_state_e            state_q, state_d;
  logic [TickW-1:0]       tick_q, tick_d;
  logic [BitW-1:0]        bit_q, bit_d;
  logic [Data_bits-1:0]   shift_q, shift_d;
  logic [Data_bits-2:0]   data_q, data_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   done_q, done_d;

  uart_rx_sync u_sync (
    .clk      (clk),
    .Reset    (Reset),
    .async_in (bus.rx),
    .sync_out (rx_s)
  );

  // State, counters, shift register and the registered result outputs.
  // Reset drops any frame in progress; no completion pulse can follow it.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic. Everything holds unless a decision is taken, so a
  // stalled s_ticks freezes the frame in place. done_d defaults low, which
  // makes rx_done_tick a single-clk pulse registered together with the new
  // data and error flags.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;

    case (state_q)
      // Wait for the line to fall; the strobe is irrelevant here, so a start
      // bit is taken on the very first clk back in idle.
      IDLE: begin
        if (!rx_s) begin
          tick_d  = '0;
          state_d = START;
        end
      end

      // At the start-bit mid-point a still-low line confirms the frame;
      // anything else was a glitch and is dropped silently.
      START: begin
        if (bus.s_ticks) begin
          if (tick_q == St_last) begin
            if (!rx_s) begin
              state_d = DATA;
              tick_d  = '0;
              bit_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + TickW'(1);
          end
        end
      end

      // Shift in from the top so the first (LSB) bit ends up at index 0 once
      // all Data_bits bits have been taken; the parity bit sits on top.
      DATA: begin
        if (bus.s_ticks) begin
          if (tick_q == Dt_last) begin
            shift_d = {rx_s, shift_q[Data_bits-1:1]};
            tick_d  = '0;
            bit_d   = bit_q + BitW'(1);
            if (bit_q == Bit_last) begin
              state_d = STOP;
            end
          end else begin
            tick_d = tick_q + TickW'(1);
          end
        end
      end

      // A low stop bit is flagged as a framing error; the word is still
      // delivered. Even parity holds when the XOR over data plus parity is 0.
      STOP: begin
        if (bus.s_ticks) begin
          if (tick_q == Sp_last) begin
            data_d  = shift_q[Data_bits-2:0];
            perr_d  = ^shift_q;
            ferr_d  = ~rx_s;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            tick_d = tick_q + TickW'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.data_out     = data_q;
  assign bus.parity_err   = perr_q;
  assign bus.frame_err    = ferr_q;
  assign bus.rx_done_tick = done_q;

endmodule
